imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 13 +
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_word_packer.sv | 43 ++++
 rtl/imem_loader.sv | 102 ++++++++++
 tb/tb_imem_loader.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [31:0] HALT_WORD_DEF = 32'h0000_007f;
  localparam logic [31:0] FILL_WORD_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP           = 32'h0000_0013;
endpackage

// File: rtl/imem_loader_if.sv
// Loader byte stream, control/status and CPU fetch port bundled as one interface.
interface imem_loader_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       q;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output start, in_valid, in_data, addr,
    input  in_ready, q, busy, done, words_loaded
  );

  modport slave (
    input  start, in_valid, in_data, addr,
    output in_ready, q, busy, done, words_loaded
  );
endinterface

// File: rtl/imem_word_packer.sv
// Packs little-endian bytes into 32-bit words; word_valid pulses with the 4th byte,
// combinationally, so the word is written on the same edge that accepts that byte.
module imem_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] hold_q, hold_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    hold_d     = hold_q;
    if (clear) begin
      byte_cnt_d = 2'd0;
    end else if (byte_valid) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    hold_d[7:0]   = byte_data;
        2'd1:    hold_d[15:8]  = byte_data;
        2'd2:    hold_d[23:16] = byte_data;
        default: hold_d        = hold_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_q <= 2'd0;
      hold_q     <= 24'd0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      hold_q     <= hold_d;
    end
  end

  assign word_valid = byte_valid && !clear && (byte_cnt_q == 2'd3);
  assign word       = {byte_data, hold_q};
endmodule

// File: rtl/imem_loader.sv
// Writable instruction memory: stream words are written from address 0 until the
// halt word or the last entry, then the tail is filled; fetch port is combinational.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = 32,
  parameter int          ADDR_W    = 5,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF,
  parameter logic [31:0] FILL_WORD = FILL_WORD_DEF
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
  logic              in_ready_q, in_ready_d;
  logic              start_ok;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              word_valid;
  logic [31:0]       word;
  logic [31:0]       mem_q [DEPTH];

  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_valid (bus.in_valid && in_ready_q),
    .byte_data  (bus.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    words_loaded_d = words_loaded_q;
    start_ok       = 1'b0;
    mem_we         = 1'b0;
    mem_wdata      = FILL_WORD;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          start_ok       = 1'b1;
          state_d        = LOAD;
          wr_ptr_d       = '0;
          words_loaded_d = '0;
        end
      end
      LOAD: begin
        if (word_valid) begin
          mem_we         = 1'b1;
          mem_wdata      = word;
          words_loaded_d = words_loaded_q + (ADDR_W+1)'(1);
          // The last-entry check wins over the halt check, so wr_ptr never wraps.
          if (wr_ptr_q == LAST) begin
            state_d = DONE;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (word == HALT_WORD) state_d = CLEAR;
          end
        end
      end
      CLEAR: begin
        mem_we = 1'b1;
        if (wr_ptr_q == LAST) state_d = DONE;
        else                  wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      words_loaded_q <= '0;
      in_ready_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      words_loaded_q <= words_loaded_d;
      in_ready_q     <= in_ready_d;
    end
  end

  // Memory contents survive reset; only the write is suppressed on a reset edge.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[wr_ptr_q] <= mem_wdata;
  end

  assign bus.q            = mem_q[bus.addr];
  assign bus.in_ready     = in_ready_q;
  assign bus.busy         = (state_q == LOAD) || (state_q == CLEAR);
  assign bus.done         = (state_q == DONE);
  assign bus.words_loaded = words_loaded_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a transaction-level memory model checked every cycle.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  imem_loader_if #(.ADDR_W(5)) bus ();

  imem_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit hold_addr = 1'b0;
  logic rdy_s = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes queue up; every 4 form a word; halt triggers tail fill one per cycle.
  logic [31:0] exp_mem [32];
  bit          known [32];
  logic [7:0]  bq [$];
  bit          m_load = 0, m_clear = 0, m_done = 0, m_ready = 0;
  int          m_ptr = 0, m_words = 0;

  initial for (int i = 0; i < 32; i++) known[i] = 1'b0;

  always @(posedge clk) begin
    logic [31:0] w;
    if (reset) begin
      m_load = 0; m_clear = 0; m_done = 0; m_ready = 0; m_words = 0;
      bq.delete();
    end else if (bus.start && !m_load && !m_clear) begin
      m_load = 1; m_done = 0; m_ready = 1; m_ptr = 0; m_words = 0;
      bq.delete();
    end else if (m_load) begin
      if (bus.in_valid && m_ready) begin
        bq.push_back(bus.in_data);
        if (bq.size() == 4) begin
          w = {bq[3], bq[2], bq[1], bq[0]};
          bq.delete();
          exp_mem[m_ptr] = w;
          known[m_ptr] = 1'b1;
          m_words++;
          if (m_ptr == 31) begin
            m_load = 0; m_ready = 0; m_done = 1;
          end else begin
            if (w == 32'h0000_007f) begin
              m_load = 0; m_ready = 0; m_clear = 1;
            end
            m_ptr++;
          end
        end
      end
    end else if (m_clear) begin
      exp_mem[m_ptr] = 32'h0;
      known[m_ptr] = 1'b1;
      if (m_ptr == 31) begin
        m_clear = 0; m_done = 1;
      end else begin
        m_ptr++;
      end
    end
  end

  always @(negedge clk) begin
    rdy_s <= bus.in_ready;
    if (chk_en) begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_ready});
      chk("busy", {31'd0, bus.busy}, {31'd0, (m_load | m_clear)});
      chk("done", {31'd0, bus.done}, {31'd0, m_done});
      chk("words_loaded", {26'd0, bus.words_loaded}, 32'(m_words));
      if (known[bus.addr]) chk("q_vs_model", bus.q, exp_mem[bus.addr]);
    end
  end

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit thr);
    bit acc;
    for (int g = 0; g < 200; g++) begin
      bus.in_data  = b;
      bus.in_valid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!hold_addr) bus.addr = 5'($urandom_range(0, 31));
      @(posedge clk);
      acc = bus.in_valid && rdy_s;
      #1;
      bus.in_valid = 1'b0;
      if (acc) return;
    end
    chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit thr);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], thr);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_image(input string name, input logic [31:0] img [32]);
    for (int a = 0; a < 32; a++) begin
      bus.addr = 5'(a);
      #1;
      chk(name, bus.q, img[a]);
    end
  endtask

  logic [31:0] prog [12];
  logic [31:0] img1 [32];
  logic [31:0] img5 [32];

  initial begin
    int n;
    bus.start = 0; bus.in_valid = 0; bus.in_data = 0; bus.addr = 0;
    prog[0] = 32'h0080_0293;
    prog[1] = 32'h00f0_0313;
    for (int i = 2; i < 11; i++) prog[i] = NOP | (32'(i) << 7);
    prog[11] = 32'h0000_007f;
    for (int i = 0; i < 32; i++) begin
      img1[i] = (i < 12) ? prog[i] : 32'h0;
      img5[i] = (i == 0) ? 32'h0000_007f : 32'h0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_words", {26'd0, bus.words_loaded}, 32'd0);
    @(posedge clk); #1;

    // 1: 12-word program ending in halt at index 11
    do_start();
    for (int i = 0; i < 12; i++) send_word(prog[i], 1'b0);
    wait_done(n);
    chk("t1_done_latency", 32'(n), 32'd20);
    check_image("t1_image", img1);
    bus.addr = 5'd0; #1 chk("t1_mem0", bus.q, 32'h0080_0293);
    bus.addr = 5'd1; #1 chk("t1_mem1", bus.q, 32'h00f0_0313);
    bus.addr = 5'd11; #1 chk("t1_mem11", bus.q, 32'h0000_007f);
    chk("t1_words", {26'd0, bus.words_loaded}, 32'd12);

    // 2: full 32 words, no halt
    @(posedge clk); #1;
    do_start();
    for (int i = 0; i < 32; i++) send_word(32'h1000_0000 + 32'(i), 1'b0);
    chk("t2_done_immediate", {31'd0, bus.done}, 32'd1);
    bus.addr = 5'd31; #1 chk("t2_mem31", bus.q, 32'h1000_001f);
    chk("t2_words", {26'd0, bus.words_loaded}, 32'd32);
    bus.in_data = 8'h7f; bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("t2_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    bus.addr = 5'd0; #1 chk("t2_mem0", bus.q, 32'h1000_0000);

    // 3: same program as 1, throttled
    do_start();
    for (int i = 0; i < 12; i++) send_word(prog[i], 1'b1);
    wait_done(n);
    chk("t3_done_latency", 32'(n), 32'd20);
    check_image("t3_image", img1);
    chk("t3_words", {26'd0, bus.words_loaded}, 32'd12);

    // 4: reset after 6 bytes
    do_start();
    send_word(32'hddcc_bbaa, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("t4_busy", {31'd0, bus.busy}, 32'd0);
    chk("t4_done", {31'd0, bus.done}, 32'd0);
    chk("t4_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.addr = 5'd0; #1 chk("t4_mem0", bus.q, 32'hddcc_bbaa);
    bus.addr = 5'd1; #1 chk("t4_mem1_kept", bus.q, 32'h00f0_0313);
    @(posedge clk); #1;
    do_start();
    for (int i = 0; i < 12; i++) send_word(prog[i], 1'b0);
    wait_done(n);
    check_image("t4_reload_image", img1);

    // 5: halt-only program, start pulse during CLEAR ignored
    do_start();
    send_word(32'h0000_007f, 1'b0);
    bus.start = 1'b1;
    n = 0;
    while (!bus.done && n < 200) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      n++;
    end
    chk("t5_clear_cycles", 32'(n), 32'd31);
    check_image("t5_image", img5);
    chk("t5_words", {26'd0, bus.words_loaded}, 32'd1);

    // 6: read-during-write at addr 2
    do_start();
    send_word(32'ha000_0000, 1'b0);
    send_word(32'ha000_0001, 1'b0);
    hold_addr = 1'b1;
    bus.addr = 5'd2;
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'ha5, 1'b0);
    bus.in_data = 8'ha5; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("t6_q_old", bus.q, 32'h0);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t6_q_new", bus.q, 32'ha5a5_1234);
    hold_addr = 1'b0;
    @(posedge clk); #1;
    send_word(32'h0000_007f, 1'b0);
    wait_done(n);
    chk("t6_done_latency", 32'(n), 32'd28);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
